// File: rtl/reg_dump_reader_if.sv
// reg_dump_reader_if: register-file read port plus the dump word stream
interface reg_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              rf_re;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_idx;
  logic              dump_last;
  modport master (
    output rf_re, rf_addr, dump_valid, dump_data, dump_idx, dump_last,
    input  rf_rdata, dump_ready
  );
  modport slave (
    input  rf_re, rf_addr, dump_valid, dump_data, dump_idx, dump_last,
    output rf_rdata, dump_ready
  );
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: on a hlt rising edge, reads FIRST_REG..LAST_REG and streams them out.
// Optional DUMP_CSUM_EN appends an XOR checksum word (idx 0) as the final word.
module reg_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  reg_dump_reader_if.master bus,
  output logic              busy,
  output logic              done
);
`ifdef DUMP_CSUM_EN
  typedef enum logic [2:0] {IDLE, RD, WAIT, CAP, OUT, CSUM, DONE} state_t;
  logic [DATA_W-1:0] csum;
`else
  typedef enum logic [2:0] {IDLE, RD, WAIT, CAP, OUT, DONE} state_t;
`endif
  state_t            state;
  logic              hlt_q;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        cnt;
  logic              start;
  logic              hs;
  logic              is_last;
  assign start   = hlt & ~hlt_q & (state == IDLE || state == DONE);
  assign hs      = bus.dump_valid & bus.dump_ready;
  assign is_last = idx == ADDR_W'(LAST_REG);
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      hlt_q          <= 1'b0;
      idx            <= '0;
      cnt            <= '0;
      bus.rf_re      <= 1'b0;
      bus.rf_addr    <= '0;
      bus.dump_valid <= 1'b0;
      bus.dump_data  <= '0;
      bus.dump_idx   <= '0;
      bus.dump_last  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
`ifdef DUMP_CSUM_EN
      csum           <= '0;
`endif
    end else begin
      hlt_q <= hlt;
      if (start) begin
        state       <= RD;
        idx         <= ADDR_W'(FIRST_REG);
        bus.rf_re   <= 1'b1;
        bus.rf_addr <= ADDR_W'(FIRST_REG);
        busy        <= 1'b1;
        done        <= 1'b0;
`ifdef DUMP_CSUM_EN
        csum        <= '0;
`endif
      end else begin
        case (state)
          RD: begin
            state     <= WAIT;
            bus.rf_re <= 1'b0;
            cnt       <= '0;
          end
          WAIT: begin
            state <= cnt == 2'(RD_LAT - 1) ? CAP : WAIT;
            cnt   <= cnt + 1'b1;
          end
          CAP: begin
            state          <= OUT;
            bus.dump_data  <= bus.rf_rdata;
            bus.dump_idx   <= idx;
            bus.dump_valid <= 1'b1;
`ifdef DUMP_CSUM_EN
            bus.dump_last  <= 1'b0;
            csum           <= csum ^ bus.rf_rdata;
`else
            bus.dump_last  <= is_last;
`endif
          end
          OUT: begin
            if (hs && !is_last) begin
              state          <= RD;
              idx            <= idx + 1'b1;
              bus.rf_re      <= 1'b1;
              bus.rf_addr    <= idx + 1'b1;
              bus.dump_valid <= 1'b0;
            end else if (hs) begin
`ifdef DUMP_CSUM_EN
              // checksum word follows immediately, already including the last register
              state          <= CSUM;
              bus.dump_data  <= csum;
              bus.dump_idx   <= '0;
              bus.dump_last  <= 1'b1;
`else
              state          <= DONE;
              bus.dump_valid <= 1'b0;
              busy           <= 1'b0;
              done           <= 1'b1;
`endif
            end
          end
`ifdef DUMP_CSUM_EN
          CSUM: begin
            if (hs) begin
              state          <= DONE;
              bus.dump_valid <= 1'b0;
              busy           <= 1'b0;
              done           <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: randomized dump runs checked against a register-list reference model
module tb_reg_dump_reader;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef DUMP_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } word_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hlt_a = 1'b0;
  logic hlt_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
  always #5 clk = ~clk;
  reg_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) ia ();
  reg_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();
  reg_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .FIRST_REG(1), .LAST_REG(31), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .hlt(hlt_a), .bus(ia.master), .busy(busy_a), .done(done_a)
  );
  reg_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .FIRST_REG(7), .LAST_REG(7), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .hlt(hlt_b), .bus(ib.master), .busy(busy_b), .done(done_b)
  );
  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];
  logic [DW-1:0] pa = '0;
  logic [DW-1:0] pb0 = '0, pb1 = '0, pb2 = '0;
  always @(posedge clk) if (ia.rf_re === 1'b1) pa <= mem_a[ia.rf_addr];
  always @(posedge clk) begin
    if (ib.rf_re === 1'b1) pb0 <= mem_b[ib.rf_addr];
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign ia.rf_rdata = pa;
  assign ib.rf_rdata = pb2;
  int re_cnt_a = 0;
  always @(posedge clk) if (ia.rf_re === 1'b1) re_cnt_a <= re_cnt_a + 1;
  int checks = 0, errors = 0;
  word_t exp_q[$], got_q[$];
  int first_lat, unstable, re_pulses;
  logic timeout, start_done, start_busy;
  function automatic void build_exp(input int first, input int last, input bit use_b);
    logic [DW-1:0] x, d;
    x = '0;
    exp_q.delete();
    for (int r = first; r <= last; r++) begin
      d = use_b ? mem_b[r] : mem_a[r];
      x ^= d;
      exp_q.push_back(word_t'{AW'(r), d, CSUM_EN ? 1'b0 : (r == last)});
    end
    if (CSUM_EN) exp_q.push_back(word_t'{'0, x, 1'b1});
  endfunction
  function automatic int mismatches();
    int n;
    n = (got_q.size() == exp_q.size()) ? 0 : 1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction
  // mode 0: ready=1, 1: ready 1-of-3, 2: random ready, 3: ready=1 with hlt re-edge mid-dump, 4: stop at idx 10
  task automatic run_a(input int mode);
    int cyc;
    logic held;
    word_t hw, cur;
    got_q.delete();
    first_lat = -1; unstable = 0; timeout = 1'b0; held = 1'b0; hw = '0; cyc = 0;
    hlt_a = 1'b0; ia.dump_ready = 1'b1;
    @(posedge clk); #1;
    re_pulses = re_cnt_a;
    hlt_a = 1'b1;
    @(posedge clk);
    forever begin
      #1;
      if (cyc == 0) begin start_done = done_a; start_busy = busy_a; end
      cur = word_t'{ia.dump_idx, ia.dump_data, ia.dump_last};
      if (held && (ia.dump_valid !== 1'b1 || cur !== hw)) unstable++;
      if (ia.dump_valid === 1'b1 && first_lat < 0) first_lat = cyc;
      if (done_a === 1'b1 && cyc > 0) break;
      if (cyc >= 1500) begin timeout = 1'b1; break; end
      if (mode == 4 && ia.dump_valid === 1'b1 && ia.dump_idx == 5'd10) begin ia.dump_ready = 1'b0; break; end
      if (mode == 3 && cyc == 40) hlt_a = 1'b0;
      if (mode == 3 && cyc == 45) hlt_a = 1'b1;
      ia.dump_ready = mode == 1 ? (cyc % 3 == 0) : mode == 2 ? 1'($urandom_range(1, 0)) : 1'b1;
      if (ia.dump_valid === 1'b1 && ia.dump_ready) got_q.push_back(cur);
      held = ia.dump_valid === 1'b1 && !ia.dump_ready;
      hw = cur;
      @(posedge clk);
      cyc++;
    end
    re_pulses = re_cnt_a - re_pulses;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ia.rf_re, ia.rf_addr, ia.dump_valid, ia.dump_data, ia.dump_idx, ia.dump_last, busy_a, done_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: re=%b addr=%0d valid=%b data=%h idx=%0d last=%b busy=%b done=%b, required all 0",
               ia.rf_re, ia.rf_addr, ia.dump_valid, ia.dump_data, ia.dump_idx, ia.dump_last, busy_a, done_a);
    end
    checks++;
    if ({ib.rf_re, ib.rf_addr, ib.dump_valid, ib.dump_data, ib.dump_idx, ib.dump_last, busy_b, done_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: re=%b valid=%b busy=%b done=%b, required all 0", ib.rf_re, ib.dump_valid, busy_b, done_b);
    end
    rst = 1'b0;
  endtask
  task automatic check_dump(input string name, input int lat, input int pulses);
    int bad;
    bad = mismatches();
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL %s_timeout: no done within budget, required done", name); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s_words: got %0d words with %0d mismatches, required %0d words exact", name, got_q.size(), bad, exp_q.size()); end
    checks++;
    if (first_lat !== lat) begin errors++; $display("FAIL %s_latency: first valid after %0d cycles, required %0d", name, first_lat, lat); end
    checks++;
    if (re_pulses !== pulses) begin errors++; $display("FAIL %s_rf_re: %0d read cycles, required %0d", name, re_pulses, pulses); end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL %s_stable: %0d unstable stall cycles, required 0", name, unstable); end
    checks++;
    if ({done_a, busy_a, start_done, start_busy} !== 4'b1001) begin
      errors++;
      $display("FAIL %s_status: done=%b busy=%b start_done=%b start_busy=%b, required 1 0 0 1", name, done_a, busy_a, start_done, start_busy);
    end
  endtask
  task automatic test_full_dump();
    mem_a[0] = '0;
    for (int n = 1; n < 32; n++) mem_a[n] = 32'h1000_0000 + n;
    build_exp(1, 31, 1'b0);
    run_a(0);
    check_dump("full", 3, 31);
  endtask
  task automatic test_ready_toggle();
    run_a(1);
    check_dump("toggle", 3, 31);
  endtask
  task automatic test_random();
    for (int n = 0; n < 32; n++) mem_a[n] = $urandom;
    build_exp(1, 31, 1'b0);
    run_a(2);
    check_dump("random", 3, 31);
  endtask
  task automatic test_reset_mid();
    run_a(4);
    checks++;
    if (timeout !== 1'b0 || ia.dump_idx !== 5'd10) begin
      errors++;
      $display("FAIL mid_reach: idx=%0d timeout=%b, required idx 10 in output", ia.dump_idx, timeout);
    end
    rst = 1'b1; hlt_a = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ia.rf_re, ia.rf_addr, ia.dump_valid, ia.dump_data, ia.dump_idx, ia.dump_last, busy_a, done_a} !== '0) begin
      errors++;
      $display("FAIL mid_reset: re=%b addr=%0d valid=%b data=%h idx=%0d last=%b busy=%b done=%b, required all 0",
               ia.rf_re, ia.rf_addr, ia.dump_valid, ia.dump_data, ia.dump_idx, ia.dump_last, busy_a, done_a);
    end
    rst = 1'b0;
    run_a(0);
    check_dump("restart", 3, 31);
  endtask
  task automatic test_hlt_reedge();
    run_a(3);
    check_dump("reedge_ignored", 3, 31);
    run_a(0);
    check_dump("reedge_after_done", 3, 31);
  endtask
  task automatic test_single_reg_lat3();
    int cyc, lat;
    logic to;
    word_t cur;
    for (int n = 0; n < 32; n++) mem_b[n] = $urandom;
    mem_b[7] = 32'hDEAD_BEEF;
    build_exp(7, 7, 1'b1);
    got_q.delete();
    cyc = 0; lat = -1; to = 1'b0;
    ib.dump_ready = 1'b1;
    @(posedge clk); #1;
    hlt_b = 1'b1;
    @(posedge clk);
    forever begin
      #1;
      cur = word_t'{ib.dump_idx, ib.dump_data, ib.dump_last};
      if (ib.dump_valid === 1'b1 && lat < 0) lat = cyc;
      if (done_b === 1'b1 && cyc > 0) break;
      if (cyc >= 200) begin to = 1'b1; break; end
      if (ib.dump_valid === 1'b1) got_q.push_back(cur);
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (to !== 1'b0 || mismatches() !== 0) begin
      errors++;
      $display("FAIL single_words: %0d words first=%h timeout=%b, required idx 7 data deadbeef", got_q.size(),
               got_q.size() > 0 ? got_q[0] : word_t'('0), to);
    end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL single_latency: first valid after %0d cycles, required 5", lat); end
    checks++;
    if ({done_b, busy_b} !== 2'b10) begin errors++; $display("FAIL single_status: done=%b busy=%b, required 1 0", done_b, busy_b); end
  endtask
`ifdef DUMP_CSUM_EN
  task automatic test_csum();
    for (int n = 0; n < 32; n++) mem_a[n] = n;
    build_exp(1, 31, 1'b0);
    run_a(0);
    check_dump("csum", 3, 31);
    checks++;
    if (got_q.size() != 32 || got_q[31] !== word_t'{5'd0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL csum_word: %0d words, required 32 ending idx 0 data 0 last 1", got_q.size());
    end
  endtask
`endif
  initial begin
    ia.dump_ready = 1'b1;
    ib.dump_ready = 1'b1;
    for (int n = 0; n < 32; n++) begin mem_a[n] = '0; mem_b[n] = '0; end
    test_reset();
    test_full_dump();
    test_ready_toggle();
    test_random();
    test_reset_mid();
    test_hlt_reedge();
    test_single_reg_lat3();
`ifdef DUMP_CSUM_EN
    test_csum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
